// File: rtl/cache_ri_refill_pkg.sv
// Shared definitions for the read-inhibit-aware cache line refill engine.
// Holds the refill FSM state encoding and the helpers that split a word
// address into line index and word-within-line index.
package cache_ri_refill_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRE_RD  = 3'd1,
    MEM_REQ = 3'd2,
    FILL    = 3'd3,
    DRE_WR  = 3'd4,
    DONE    = 3'd5
  } refillState_t;

  // Bits needed to index a word inside a line.
  function automatic int wordIdxWidth(input int lineWords);
    return $clog2(lineWords);
  endfunction

  // Bits left over for the line (set) index.
  function automatic int lineIdxWidth(input int addrWidth, input int lineWords);
    return addrWidth - $clog2(lineWords);
  endfunction

endpackage

// File: rtl/cache_ri_refill.sv
// Cache line refill engine that never overwrites bytes already marked
// readable. A refill reads the per-byte readable (dre) bits of the line,
// bursts the line in from memory, writes only the bytes not yet readable,
// then marks the whole line readable.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, start_line,
//   start_channel,
//   start_memAddress      refill request (sampled only when idle)
//   busy, done            status; done pulses one cycle at completion
//   dre_sel               routes the dre store to this block (== busy)
//   dre_read*             dre read port (data one cycle after address)
//   dre_write*            dre write port (marks pairs of words readable)
//   mem_*                 burst read master (waitrequest / readdatavalid)
//   data_write*           data RAM write port with byte enables
module cache_ri_refill
  import cache_ri_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int LINE_WORDS = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [ADDR_WIDTH-$clog2(LINE_WORDS)-1:0] start_line,
  input  logic [1:0]                             start_channel,
  input  logic [31:0]                            start_memAddress,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   dre_sel,
  output logic [ADDR_WIDTH-1:0]                  dre_readAddress,
  output logic [1:0]                             dre_readChannel,
  input  logic [7:0]                             dre_readData,
  output logic [ADDR_WIDTH-1:0]                  dre_writeAddress,
  output logic [1:0]                             dre_writeChannel,
  output logic                                   dre_writeEnable,
  output logic [7:0]                             dre_writeData,
  output logic [31:0]                            mem_address,
  output logic                                   mem_read,
  output logic [7:0]                             mem_burstcount,
  input  logic                                   mem_waitrequest,
  input  logic [31:0]                            mem_readdata,
  input  logic                                   mem_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                  data_writeAddress,
  output logic [1:0]                             data_writeChannel,
  output logic [31:0]                            data_writeData,
  output logic [3:0]                             data_writeByteEnable,
  output logic                                   data_writeEnable
);

  localparam int WORD_W = wordIdxWidth(LINE_WORDS);
  localparam int LINE_W = lineIdxWidth(ADDR_WIDTH, LINE_WORDS);
  localparam int PAIRS  = LINE_WORDS / 2;

  localparam logic [WORD_W-1:0] RD_LAST   = WORD_W'(PAIRS);
  localparam logic [WORD_W-1:0] PAIR_LAST = WORD_W'(PAIRS - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(LINE_WORDS - 1);

  refillState_t state, stateNext;

  // One counter serves every phase: dre read cycles, fill beats and dre
  // write cycles. It clears on every state change. Word arithmetic wraps
  // inside WORD_W bits, so it never carries into the line index.
  logic [WORD_W-1:0]       cnt;
  logic                    cntInc;
  logic [WORD_W-1:0]       pairWord;
  logic [WORD_W-1:0]       capIdx;

  logic [LINE_W-1:0]       lineReg;
  logic [1:0]              chanReg;
  logic [31:0]             memAddrReg;
  logic [LINE_WORDS*4-1:0] readMask;

  logic [3:0]              beatMask;
  logic                    beat;

  assign pairWord = cnt << 1;
  assign capIdx   = cnt - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      lineReg    <= '0;
      chanReg    <= '0;
      memAddrReg <= '0;
      readMask   <= '0;
    end else begin
      state <= stateNext;

      if (state != stateNext) begin
        cnt <= '0;
      end else if (cntInc) begin
        cnt <= cnt + 1'b1;
      end

      if (state == IDLE && start) begin
        lineReg    <= start_line;
        chanReg    <= start_channel;
        memAddrReg <= start_memAddress;
      end

      // Read data returns one cycle after its address, so the entry
      // landing now belongs to the previous pair index.
      if (state == DRE_RD && cnt != '0) begin
        for (int k = 0; k < PAIRS; k++) begin
          if (capIdx == WORD_W'(k)) begin
            readMask[8*k +: 8] <= dre_readData;
          end
        end
      end
    end
  end

  always_comb begin
    stateNext = state;
    cntInc    = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = DRE_RD;
      end
      DRE_RD: begin
        cntInc = 1'b1;
        if (cnt == RD_LAST) stateNext = MEM_REQ;
      end
      MEM_REQ: begin
        if (!mem_waitrequest) stateNext = FILL;
      end
      FILL: begin
        cntInc = mem_readdatavalid;
        if (mem_readdatavalid && cnt == WORD_LAST) stateNext = DRE_WR;
      end
      DRE_WR: begin
        cntInc = 1'b1;
        if (cnt == PAIR_LAST) stateNext = DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Readable bits of the word currently being filled.
  always_comb begin
    beatMask = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (cnt == WORD_W'(w)) beatMask = readMask[4*w +: 4];
    end
  end

  assign beat = (state == FILL) && mem_readdatavalid;

  always_comb begin
    busy                 = (state != IDLE);
    dre_sel              = busy;
    done                 = (state == DONE);

    dre_readChannel      = busy ? chanReg : 2'b00;
    dre_writeChannel     = busy ? chanReg : 2'b00;
    data_writeChannel    = busy ? chanReg : 2'b00;

    dre_readAddress      = (state == DRE_RD) ? {lineReg, pairWord} : '0;

    dre_writeEnable      = (state == DRE_WR);
    dre_writeAddress     = dre_writeEnable ? {lineReg, pairWord} : '0;
    dre_writeData        = dre_writeEnable ? 8'hFF : 8'h00;

    mem_read             = (state == MEM_REQ);
    mem_address          = mem_read ? memAddrReg : 32'h0;
    mem_burstcount       = mem_read ? 8'(LINE_WORDS) : 8'h00;

    // Only bytes not yet readable are written; a fully readable word
    // produces no write at all.
    data_writeAddress    = beat ? {lineReg, cnt} : '0;
    data_writeData       = beat ? mem_readdata : 32'h0;
    data_writeByteEnable = beat ? ~beatMask : 4'h0;
    data_writeEnable     = beat && (beatMask != 4'hF);
  end

endmodule

// File: tb/tb_cache_ri_refill.sv
module tb_cache_ri_refill;

  localparam int AW = 9;
  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  start_line;
  logic [1:0]  start_channel;
  logic [31:0] start_memAddress;
  logic        busy, done, dre_sel;
  logic [AW-1:0] dre_readAddress;
  logic [1:0]  dre_readChannel;
  logic [7:0]  dre_readData;
  logic [AW-1:0] dre_writeAddress;
  logic [1:0]  dre_writeChannel;
  logic        dre_writeEnable;
  logic [7:0]  dre_writeData;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [7:0]  mem_burstcount;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [AW-1:0] data_writeAddress;
  logic [1:0]  data_writeChannel;
  logic [31:0] data_writeData;
  logic [3:0]  data_writeByteEnable;
  logic        data_writeEnable;

  always #5 clk = ~clk;

  cache_ri_refill #(.ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .start_line(start_line), .start_channel(start_channel),
    .start_memAddress(start_memAddress),
    .busy(busy), .done(done), .dre_sel(dre_sel),
    .dre_readAddress(dre_readAddress), .dre_readChannel(dre_readChannel),
    .dre_readData(dre_readData),
    .dre_writeAddress(dre_writeAddress), .dre_writeChannel(dre_writeChannel),
    .dre_writeEnable(dre_writeEnable), .dre_writeData(dre_writeData),
    .mem_address(mem_address), .mem_read(mem_read),
    .mem_burstcount(mem_burstcount), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid),
    .data_writeAddress(data_writeAddress), .data_writeChannel(data_writeChannel),
    .data_writeData(data_writeData), .data_writeByteEnable(data_writeByteEnable),
    .data_writeEnable(data_writeEnable)
  );

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } dataExp_t;

  dataExp_t    expData[$];
  logic [8:0]  expDre[$];
  dataExp_t    monE;
  logic [8:0]  monA;

  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0]  dreRam [0:511];
  logic [7:0]  dreInit [0:3];
  logic [31:0] beatData [0:7];
  logic [1:0]  curChan;
  logic [31:0] curAddr;
  int waitCycles, gapCycles;
  int cyc, doneCount, doneCyc, lastDreCyc, dataWrCount, dreWrCount;
  int memReadCycles, busyDrops;
  bit refillActive;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // dre store model: registered read, one cycle latency
  always @(posedge clk) dre_readData <= dreRam[dre_readAddress];

  // Memory slave: holds waitrequest for waitCycles, then returns LW beats,
  // each preceded by gapCycles idle cycles.
  initial begin
    mem_waitrequest   = 1'b1;
    mem_readdatavalid = 1'b0;
    mem_readdata      = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_read) begin
        repeat (waitCycles) begin @(posedge clk); #1; end
        mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        mem_waitrequest = 1'b1;
        for (int b = 0; b < LW; b++) begin
          repeat (gapCycles) begin @(posedge clk); #1; end
          mem_readdatavalid = 1'b1;
          mem_readdata      = beatData[b];
          @(posedge clk); #1;
          mem_readdatavalid = 1'b0;
          mem_readdata      = 32'h0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every write the DUT produces.
  initial begin
    cyc = 0; doneCount = 0; doneCyc = 0; lastDreCyc = 0;
    dataWrCount = 0; dreWrCount = 0; memReadCycles = 0; busyDrops = 0;
    refillActive = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        checkEq("dreSel", dre_sel, busy);
        if (busy) checkEq("rdChan", dre_readChannel, curChan);
        if (mem_read) begin
          memReadCycles++;
          checkEq("memAddr", mem_address, curAddr);
          checkEq("burst", mem_burstcount, 8);
        end
        if (data_writeEnable) begin
          dataWrCount++;
          if (expData.size() == 0) checkEq("dataUnexpected", 1, 0);
          else begin
            monE = expData.pop_front();
            checkEq("dAddr", data_writeAddress, monE.addr);
            checkEq("dData", data_writeData, monE.data);
            checkEq("dBe", data_writeByteEnable, monE.be);
            checkEq("dChan", data_writeChannel, curChan);
          end
        end
        if (dre_writeEnable) begin
          dreWrCount++;
          lastDreCyc = cyc;
          if (expDre.size() == 0) checkEq("dreUnexpected", 1, 0);
          else begin
            monA = expDre.pop_front();
            checkEq("dreAddr", dre_writeAddress, monA);
            checkEq("dreData", dre_writeData, 8'hFF);
            checkEq("dreChan", dre_writeChannel, curChan);
          end
        end
        if (refillActive && !busy) busyDrops++;
        if (done) begin
          doneCount++;
          doneCyc = cyc;
          refillActive = 1'b0;
        end
      end
    end
  end

  // Loads dre entries for the line and pushes the expected writes.
  task automatic prepare(input logic [5:0] line, input logic [1:0] chan,
                         input logic [31:0] addr, input int wc, input int gc,
                         output int nExp);
    logic [7:0] ent;
    logic [3:0] nib;
    dataExp_t e;
    curChan = chan; curAddr = addr; waitCycles = wc; gapCycles = gc;
    nExp = 0;
    for (int k = 0; k < 4; k++) dreRam[{line, 3'(2*k)}] = dreInit[k];
    for (int w = 0; w < LW; w++) begin
      ent = dreInit[w/2];
      nib = (w % 2 == 0) ? ent[3:0] : ent[7:4];
      if (nib != 4'hF) begin
        e.addr = {line, 3'(w)};
        e.data = beatData[w];
        e.be   = ~nib;
        expData.push_back(e);
        nExp++;
      end
    end
    for (int k = 0; k < 4; k++) expDre.push_back({line, 3'(2*k)});
    memReadCycles = 0;
    busyDrops = 0;
  endtask

  task automatic pulseStart(input logic [5:0] line, input logic [1:0] chan,
                            input logic [31:0] addr);
    @(posedge clk); #1;
    start = 1'b1; start_line = line; start_channel = chan; start_memAddress = addr;
    @(posedge clk); #1;
    start = 1'b0; start_line = '0; start_channel = '0; start_memAddress = '0;
    refillActive = 1'b1;
  endtask

  task automatic runRefill(input logic [5:0] line, input logic [1:0] chan,
                           input logic [31:0] addr, input int wc, input int gc,
                           input bit pokeFill, input bit pokeDone);
    int nExp, d0, w0, r0;
    bit poked;
    poked = 1'b0;
    prepare(line, chan, addr, wc, gc, nExp);
    d0 = doneCount; w0 = dataWrCount; r0 = dreWrCount;
    pulseStart(line, chan, addr);
    for (int t = 0; t < 400 && doneCount == d0; t++) begin
      @(posedge clk); #2;
      if (pokeFill && !poked && (dataWrCount - w0) >= 2) begin
        poked = 1'b1;
        start = 1'b1; start_line = 6'h2A; start_channel = 2'd1; start_memAddress = 32'hDEAD_0000;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (pokeDone && !poked && done) begin
        poked = 1'b1;
        start = 1'b1; start_line = 6'h15; start_channel = 2'd2; start_memAddress = 32'hBEEF_0000;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    if (doneCount == d0) checkEq("doneTimeout", 0, 1);
    repeat (12) @(posedge clk);
    #2;
    checkEq("doneCount", doneCount - d0, 1);
    checkEq("busyAfter", busy, 0);
    checkEq("dataWrN", dataWrCount - w0, nExp);
    checkEq("dreWrN", dreWrCount - r0, 4);
    checkEq("dataLeft", expData.size(), 0);
    checkEq("dreLeft", expDre.size(), 0);
    checkEq("doneLat", doneCyc - lastDreCyc, 1);
    checkEq("memRdCycles", memReadCycles, wc + 1);
    checkEq("busyDrops", busyDrops, 0);
    expData.delete();
    expDre.delete();
  endtask

  initial begin
    int nExp, r0;
    rst_n = 1'b0;
    start = 1'b0; start_line = '0; start_channel = '0; start_memAddress = '0;
    curChan = '0; curAddr = '0; waitCycles = 0; gapCycles = 0;
    for (int i = 0; i < 512; i++) dreRam[i] = 8'h00;
    for (int i = 0; i < 4; i++) dreInit[i] = 8'h00;
    for (int i = 0; i < LW; i++) beatData[i] = 32'h1111_1111 * (i + 1);

    @(negedge clk);
    checkEq("rstBusy", busy, 0);
    checkEq("rstDone", done, 0);
    checkEq("rstSel", dre_sel, 0);
    checkEq("rstMemRd", mem_read, 0);
    checkEq("rstDreWe", dre_writeEnable, 0);
    checkEq("rstDataWe", data_writeEnable, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // all bytes writable, plain back-to-back beats
    runRefill(6'd3, 2'd0, 32'h0000_0180, 0, 0, 1'b0, 1'b1);

    // word 0 fully readable
    dreInit[0] = 8'h0F; dreInit[1] = 8'h00; dreInit[2] = 8'h00; dreInit[3] = 8'h00;
    for (int i = 0; i < LW; i++) beatData[i] = 32'hA0A0_0000 + i;
    runRefill(6'd5, 2'd1, 32'h0000_0280, 0, 0, 1'b0, 1'b0);

    // mixed readable bytes in entry 1
    dreInit[0] = 8'h00; dreInit[1] = 8'hA5; dreInit[2] = 8'hFF; dreInit[3] = 8'h3C;
    runRefill(6'd9, 2'd2, 32'h0000_0480, 0, 0, 1'b0, 1'b0);

    // waitrequest held, gapped beats
    for (int i = 0; i < 4; i++) dreInit[i] = 8'h00;
    for (int i = 0; i < LW; i++) beatData[i] = 32'h1111_1111 * (i + 1);
    runRefill(6'd12, 2'd3, 32'h0000_0600, 5, 2, 1'b0, 1'b0);

    // start during FILL is ignored
    runRefill(6'd20, 2'd1, 32'h0000_0A00, 0, 1, 1'b1, 1'b0);

    // reset during beat 3
    for (int i = 0; i < LW; i++) beatData[i] = 32'hC0DE_0000 + i;
    prepare(6'd30, 2'd2, 32'h0000_0F00, 0, 0, nExp);
    r0 = dreWrCount;
    pulseStart(6'd30, 2'd2, 32'h0000_0F00);
    begin
      bit hit;
      hit = 1'b0;
      for (int t = 0; t < 200 && !hit; t++) begin
        @(posedge clk); #2;
        if (data_writeEnable && data_writeAddress[2:0] == 3'd3) hit = 1'b1;
      end
      checkEq("beat3Seen", hit, 1);
    end
    rst_n = 1'b0;
    #1;
    checkEq("abortBusy", busy, 0);
    checkEq("abortDone", done, 0);
    checkEq("abortSel", dre_sel, 0);
    checkEq("abortMemRd", mem_read, 0);
    checkEq("abortDreWe", dre_writeEnable, 0);
    checkEq("abortDataWe", data_writeEnable, 0);
    checkEq("abortDataAddr", data_writeAddress, 0);
    expData.delete();
    expDre.delete();
    refillActive = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    checkEq("abortNoDre", dreWrCount - r0, 0);
    checkEq("abortIdle", busy, 0);

    // normal refill after abort, top line index, random contents
    for (int i = 0; i < 4; i++) dreInit[i] = 8'($urandom);
    for (int i = 0; i < LW; i++) beatData[i] = $urandom;
    runRefill(6'd63, 2'd3, 32'h0000_7E00, 1, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
